repairmb_sequencer: RTL and testbench
=====================================

// Module: repairmb_sequencer
// PURPOSE
// - Sequences the MBINIT REPAIRMB step over one lane-repair pass:
//   sideband start handshake, lane test, functional-lane setup, degrade handshake.
// - Drives start_setup to the functional-lane setup block and consumes done_setup / o_Functional_Lanes.
// - Merges local and remote lane maps (bitwise AND) into the final lane map.
// - Reports done or error to the MBINIT top FSM.
// PARAMETERS
// - TIMEOUT_CYCLES  default 8000  cycles allowed in any WAIT_* state before error
// - CNT_W           default 13    timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// - MAX_RETRY       default 2     test retries when local map is 2'b00 (REPAIRMB_RETRY_EN only)
// PORTS
// - CLK                 in   1   clock
// - rst_n               in   1   async active-low reset
// - i_start_repairmb    in   1   1-cycle start pulse; ignored unless state is IDLE
// - o_sb_msg_valid      out  1   sideband request valid; held until accepted
// - o_sb_msg_id         out  2   1=START_REQ, 2=APPLY_DEGRADE_REQ, 3=END_REQ
// - o_sb_msg_data       out  2   lane map carried with APPLY_DEGRADE_REQ, else 0
// - i_sb_msg_ready      in   1   request accepted when valid&&ready
// - i_sb_rsp_valid      in   1   1-cycle response pulse
// - i_sb_rsp_id         in   2   response id (same codes as the request)
// - i_sb_rsp_data       in   2   remote lane map carried with the degrade response
// - o_test_start        out  1   1-cycle pulse starting the lane test
// - i_test_done         in   1   1-cycle pulse; i_lanes_results_tx is valid that cycle
// - o_start_setup       out  1   1-cycle pulse to the setup block
// - i_done_setup        in   1   setup done pulse
// - i_Functional_Lanes  in   2   local map from the setup block (11/10/01/00)
// - o_final_lanes       out  2   local & remote map; valid when o_repairmb_done
// - o_repairmb_done     out  1   level; held until next accepted start
// - o_repairmb_error    out  1   level; held until next accepted start
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 except o_final_lanes=2'b11; counters cleared.
// - Reset mid-operation aborts immediately; no END_REQ is sent.
// - FSM: IDLE -start-> SEND_START -accept-> WAIT_START_RSP -rsp id1-> TEST.
// - TEST: pulse o_test_start for 1 cycle -> WAIT_TEST -i_test_done-> SETUP.
// - SETUP: pulse o_start_setup for 1 cycle -> WAIT_SETUP -i_done_setup-> CHECK.
// - CHECK: i_Functional_Lanes==00 -> ERROR; otherwise SEND_DEGRADE with data=local map.
// - SEND_DEGRADE -accept-> WAIT_DEGRADE_RSP -rsp id2-> MERGE.
// - MERGE: final=local&remote; final==00 -> ERROR, else SEND_END.
// - SEND_END -accept-> WAIT_END_RSP -rsp id3-> DONE.
// - DONE and ERROR return to IDLE next cycle; done/error flags stay latched.
// - Accepted start clears done, error and sets o_final_lanes=11.
// - Latency, lane test and setup handshakes: o_test_start/o_start_setup assert the cycle after
//   entering TEST/SETUP.
// - Responses that arrive the same cycle as the accept are honoured.
// - Responses with a mismatched id are ignored and do not reset the timer.
// - Timer clears on each state entry and counts only in WAIT_* states.
// - Reaching TIMEOUT_CYCLES -> ERROR; o_sb_msg_valid drops the same cycle.
// - o_sb_msg_valid/id/data stable while valid&&!ready.
// - Done/error pulses from downstream blocks in the wrong state are ignored.
// CONFIGURATION
// - REPAIRMB_RETRY_EN defined: CHECK with map 00 and retry count < MAX_RETRY increments the
//   count and goes to TEST. Count clears on start.
// - REPAIRMB_RETRY_EN undefined: no retry; map 00 -> ERROR directly.
// TESTING
// - All 16 lanes pass, remote=11; every ready same cycle -> final=11, done=1, error=0,
//   three sb requests in order 1,2,3.
// - Local map 10, remote 01 -> final=00, error=1, no END_REQ issued.
// - Local map 01, remote 11 with ready delayed 5 cycles -> data stable while waiting;
//   final=01, done=1.
// - No start response -> error=1 exactly TIMEOUT_CYCLES cycles after entering
//   WAIT_START_RSP; valid=0.
// - Local map 00: without retry -> error after 1 test; with REPAIRMB_RETRY_EN and
//   MAX_RETRY=2 -> 3 test pulses, then error.
// - rst_n low during WAIT_SETUP, then i_start_repairmb -> outputs at reset values;
//   fresh START_REQ sequence completes.

Source files
------------

// File: rtl/repairmb_sequencer.sv
// MBINIT REPAIRMB sequencer: start handshake, lane test, lane setup, degrade and end handshakes.
// Optional retry of the lane test on an all-failed local map is enabled with REPAIRMB_RETRY_EN.
module repairmb_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 8000,
  parameter int unsigned CNT_W          = 13,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_start_repairmb,
  output logic       o_sb_msg_valid,
  output logic [1:0] o_sb_msg_id,
  output logic [1:0] o_sb_msg_data,
  input  logic       i_sb_msg_ready,
  input  logic       i_sb_rsp_valid,
  input  logic [1:0] i_sb_rsp_id,
  input  logic [1:0] i_sb_rsp_data,
  output logic       o_test_start,
  input  logic       i_test_done,
  output logic       o_start_setup,
  input  logic       i_done_setup,
  input  logic [1:0] i_Functional_Lanes,
  output logic [1:0] o_final_lanes,
  output logic       o_repairmb_done,
  output logic       o_repairmb_error
);

  localparam logic [1:0] MSG_START   = 2'd1;
  localparam logic [1:0] MSG_DEGRADE = 2'd2;
  localparam logic [1:0] MSG_END     = 2'd3;

  typedef enum logic [3:0] {
    IDLE, SEND_START, WAIT_START_RSP, TEST, WAIT_TEST, SETUP, WAIT_SETUP, CHECK,
    SEND_DEGRADE, WAIT_DEGRADE_RSP, MERGE, SEND_END, WAIT_END_RSP, DONE, ERROR
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] timer;
  logic [1:0]       local_map, remote_map, merged, phase_id;
  logic             is_wait, timed_out, sb_accept, rsp_match, retry_ok, start_acc;

  if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end
  if (MAX_RETRY > 255) begin : g_bad_max_retry
    $error("MAX_RETRY exceeds the 8-bit retry counter");
  end

  // Message id belongs to the whole send/wait phase so responses can be matched in either state
  always_comb begin
    phase_id = 2'd0;
    case (state)
      SEND_START,   WAIT_START_RSP:   phase_id = MSG_START;
      SEND_DEGRADE, WAIT_DEGRADE_RSP: phase_id = MSG_DEGRADE;
      SEND_END,     WAIT_END_RSP:     phase_id = MSG_END;
      default:                        phase_id = 2'd0;
    endcase
  end

  assign o_sb_msg_valid = state inside {SEND_START, SEND_DEGRADE, SEND_END};
  assign o_sb_msg_id    = o_sb_msg_valid ? phase_id : 2'd0;
  assign o_sb_msg_data  = (state == SEND_DEGRADE) ? local_map : 2'd0;
  assign sb_accept      = o_sb_msg_valid && i_sb_msg_ready;
  assign rsp_match      = i_sb_rsp_valid && (i_sb_rsp_id == phase_id);
  assign is_wait        = state inside {WAIT_START_RSP, WAIT_TEST, WAIT_SETUP,
                                        WAIT_DEGRADE_RSP, WAIT_END_RSP};
  assign timed_out      = is_wait && (timer == CNT_W'(TIMEOUT_CYCLES - 1));
  assign merged         = local_map & remote_map;
  assign start_acc      = (state == IDLE) && i_start_repairmb;

`ifdef REPAIRMB_RETRY_EN
  logic [7:0] retry_cnt;

  assign retry_ok = (retry_cnt < 8'(MAX_RETRY));

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= 8'd0;
    end else if (start_acc) begin
      retry_cnt <= 8'd0;
    end else if ((state == CHECK) && (local_map == 2'b00) && retry_ok) begin
      retry_cnt <= retry_cnt + 8'd1;
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:             if (i_start_repairmb) next_state = SEND_START;
      SEND_START:       if (sb_accept) next_state = rsp_match ? TEST : WAIT_START_RSP;
      WAIT_START_RSP:   if (rsp_match) next_state = TEST;
                        else if (timed_out) next_state = ERROR;
      TEST:             next_state = WAIT_TEST;
      WAIT_TEST:        if (i_test_done) next_state = SETUP;
                        else if (timed_out) next_state = ERROR;
      SETUP:            next_state = WAIT_SETUP;
      WAIT_SETUP:       if (i_done_setup) next_state = CHECK;
                        else if (timed_out) next_state = ERROR;
      CHECK:            if (local_map == 2'b00) next_state = retry_ok ? TEST : ERROR;
                        else next_state = SEND_DEGRADE;
      SEND_DEGRADE:     if (sb_accept) next_state = rsp_match ? MERGE : WAIT_DEGRADE_RSP;
      WAIT_DEGRADE_RSP: if (rsp_match) next_state = MERGE;
                        else if (timed_out) next_state = ERROR;
      MERGE:            next_state = (merged == 2'b00) ? ERROR : SEND_END;
      SEND_END:         if (sb_accept) next_state = rsp_match ? DONE : WAIT_END_RSP;
      WAIT_END_RSP:     if (rsp_match) next_state = DONE;
                        else if (timed_out) next_state = ERROR;
      DONE, ERROR:      next_state = IDLE;
      default:          next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      timer            <= '0;
      local_map        <= 2'b00;
      remote_map       <= 2'b00;
      o_test_start     <= 1'b0;
      o_start_setup    <= 1'b0;
      o_final_lanes    <= 2'b11;
      o_repairmb_done  <= 1'b0;
      o_repairmb_error <= 1'b0;
    end else begin
      o_test_start  <= (state == TEST);
      o_start_setup <= (state == SETUP);
      if (next_state != state) timer <= '0;
      else if (is_wait)        timer <= timer + 1'b1;
      // Maps are captured on the transition so a same-cycle response is not lost
      if (next_state == CHECK) local_map  <= i_Functional_Lanes;
      if (next_state == MERGE) remote_map <= i_sb_rsp_data;
      if (start_acc) begin
        o_repairmb_done  <= 1'b0;
        o_repairmb_error <= 1'b0;
        o_final_lanes    <= 2'b11;
      end
      if (state == MERGE)      o_final_lanes    <= merged;
      if (next_state == DONE)  o_repairmb_done  <= 1'b1;
      if (next_state == ERROR) o_repairmb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_repairmb_sequencer.sv
// Bench for repairmb_sequencer: bench-driven sideband/test/setup responders with a scenario-level model.
module tb_repairmb_sequencer;

  localparam int TO  = 40;
  localparam int MRT = 2;

  logic       CLK, rst_n, i_start_repairmb;
  logic       o_sb_msg_valid, i_sb_msg_ready, i_sb_rsp_valid;
  logic [1:0] o_sb_msg_id, o_sb_msg_data, i_sb_rsp_id, i_sb_rsp_data;
  logic       o_test_start, i_test_done, o_start_setup, i_done_setup;
  logic [1:0] i_Functional_Lanes, o_final_lanes;
  logic       o_repairmb_done, o_repairmb_error;

  int n_cmp = 0;
  int n_fail = 0;

  repairmb_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(6), .MAX_RETRY(MRT)) dut (
    .CLK(CLK), .rst_n(rst_n), .i_start_repairmb(i_start_repairmb),
    .o_sb_msg_valid(o_sb_msg_valid), .o_sb_msg_id(o_sb_msg_id), .o_sb_msg_data(o_sb_msg_data),
    .i_sb_msg_ready(i_sb_msg_ready), .i_sb_rsp_valid(i_sb_rsp_valid), .i_sb_rsp_id(i_sb_rsp_id),
    .i_sb_rsp_data(i_sb_rsp_data), .o_test_start(o_test_start), .i_test_done(i_test_done),
    .o_start_setup(o_start_setup), .i_done_setup(i_done_setup),
    .i_Functional_Lanes(i_Functional_Lanes), .o_final_lanes(o_final_lanes),
    .o_repairmb_done(o_repairmb_done), .o_repairmb_error(o_repairmb_error)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    i_start_repairmb = 1'b0;
    i_sb_msg_ready   = 1'b0;
    i_sb_rsp_valid   = 1'b0;
    i_sb_rsp_id      = 2'd0;
    i_sb_rsp_data    = 2'd0;
    i_test_done      = 1'b0;
    i_done_setup     = 1'b0;
  endtask

  // One REPAIRMB pass. The bench answers every request; expectations come from the pass rules.
  task automatic run_txn(input logic [1:0] lmap, input logic [1:0] rmap, input int rdy_dly,
                         input int rsp_dly, input bit noise, input bit abort_at_setup);
    int ids[$];
    int exp_ids[$];
    int tests = 0, setups = 0, waitc = 0, tdone_cnt = 0, sdone_cnt = 0, rsp_cnt = 0;
    int exp_tests;
    bit fin = 1'b0, holding = 1'b0, exp_err;
    logic [1:0] hold_id = 2'd0, hold_data = 2'd0, rsp_id_q = 2'd0, rsp_data_q = 2'd0;
    logic [1:0] exp_final;

    if (lmap == 2'b00) begin
      exp_ids   = '{1};
      exp_final = 2'b11;
      exp_err   = 1'b1;
`ifdef REPAIRMB_RETRY_EN
      exp_tests = MRT + 1;
`else
      exp_tests = 1;
`endif
    end else begin
      exp_final = lmap & rmap;
      exp_err   = (exp_final == 2'b00);
      exp_tests = 1;
      if (exp_err) exp_ids = '{1, 2};
      else         exp_ids = '{1, 2, 3};
    end

    i_Functional_Lanes = lmap;
    i_start_repairmb   = 1'b1;
    @(negedge CLK);
    i_start_repairmb = 1'b0;
    check("start_clr_done", o_repairmb_done, 1'b0);
    check("start_clr_err", o_repairmb_error, 1'b0);
    check("start_final11", o_final_lanes, 2'b11);

    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      i_test_done = 1'b0; i_done_setup = 1'b0; i_sb_rsp_valid = 1'b0; i_sb_msg_ready = 1'b0;
      if (abort_at_setup && o_start_setup) return;
      if (o_repairmb_done || o_repairmb_error) begin
        fin = 1'b1;
      end else begin
        if (o_test_start) begin
          tests++;
          tdone_cnt = 1 + $urandom_range(0, 3);
          if (noise) i_done_setup = 1'b1;
        end
        if (o_start_setup) begin
          setups++;
          sdone_cnt = 1 + $urandom_range(0, 3);
        end
        if (tdone_cnt > 0) begin
          tdone_cnt--;
          if (tdone_cnt == 0) i_test_done = 1'b1;
        end
        if (sdone_cnt > 0) begin
          sdone_cnt--;
          if (sdone_cnt == 0) i_done_setup = 1'b1;
        end
        if (rsp_cnt > 0) begin
          rsp_cnt--;
          if (rsp_cnt == 0) begin
            i_sb_rsp_valid = 1'b1; i_sb_rsp_id = rsp_id_q; i_sb_rsp_data = rsp_data_q;
          end else if (noise) begin
            i_sb_rsp_valid = 1'b1; i_sb_rsp_id = 2'((rsp_id_q % 3) + 1); i_sb_rsp_data = ~rmap;
          end
        end
        if (o_sb_msg_valid) begin
          if (!holding) begin
            holding = 1'b1; hold_id = o_sb_msg_id; hold_data = o_sb_msg_data; waitc = 0;
          end else begin
            check("sb_stable", {o_sb_msg_id, o_sb_msg_data}, {hold_id, hold_data});
          end
          if (waitc >= rdy_dly) begin
            i_sb_msg_ready = 1'b1;
            holding = 1'b0;
            ids.push_back(int'(o_sb_msg_id));
            check("sb_data", o_sb_msg_data, (o_sb_msg_id == 2'd2) ? lmap : 2'b00);
            rsp_id_q   = o_sb_msg_id;
            rsp_data_q = (o_sb_msg_id == 2'd2) ? rmap : 2'b00;
            if (rsp_dly == 0) begin
              i_sb_rsp_valid = 1'b1; i_sb_rsp_id = rsp_id_q; i_sb_rsp_data = rsp_data_q;
            end else begin
              rsp_cnt = rsp_dly;
            end
          end else begin
            waitc++;
          end
        end
      end
      if (!fin) @(negedge CLK);
    end
    clear_inputs();

    check("txn_budget", fin, 1'b1);
    check("txn_done", o_repairmb_done, !exp_err);
    check("txn_error", o_repairmb_error, exp_err);
    check("txn_final", o_final_lanes, exp_final);
    check("txn_valid_low", o_sb_msg_valid, 1'b0);
    check("txn_tests", tests, exp_tests);
    check("txn_setups", setups, exp_tests);
    check("txn_nreq", ids.size(), exp_ids.size());
    for (int i = 0; i < ids.size() && i < exp_ids.size(); i++)
      check("txn_req_id", ids[i], exp_ids[i]);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int k;
    clear_inputs();
    i_Functional_Lanes = 2'b11;
    rst_n = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_valid", o_sb_msg_valid, 1'b0);
    check("rst_id", o_sb_msg_id, 2'd0);
    check("rst_final", o_final_lanes, 2'b11);
    check("rst_done", o_repairmb_done, 1'b0);
    check("rst_error", o_repairmb_error, 1'b0);
    check("rst_pulses", {o_test_start, o_start_setup}, 2'b00);
    rst_n = 1'b1;
    @(negedge CLK);

    // Directed scenarios
    run_txn(2'b11, 2'b11, 0, 0, 1'b0, 1'b0);
    run_txn(2'b10, 2'b01, 0, 1, 1'b0, 1'b0);
    run_txn(2'b01, 2'b11, 5, 2, 1'b1, 1'b0);
    run_txn(2'b00, 2'b11, 1, 1, 1'b0, 1'b0);

    // Start response never arrives; a wrong-id response mid-wait must not restart the timer
    i_start_repairmb = 1'b1;
    @(negedge CLK);
    i_start_repairmb = 1'b0;
    check("to_valid", o_sb_msg_valid, 1'b1);
    i_sb_msg_ready = 1'b1;
    @(negedge CLK);
    i_sb_msg_ready = 1'b0;
    k = 0;
    while (!o_repairmb_error && k < TO + 20) begin
      i_sb_rsp_valid = (k == 10);
      i_sb_rsp_id    = 2'd2;
      @(negedge CLK);
      k++;
    end
    clear_inputs();
    check("to_latency", k, TO);
    check("to_error", o_repairmb_error, 1'b1);
    check("to_done", o_repairmb_done, 1'b0);
    check("to_valid_low", o_sb_msg_valid, 1'b0);
    repeat (2) @(negedge CLK);

    // Reset while waiting for setup completion, then a fresh pass
    run_txn(2'b11, 2'b11, 0, 1, 1'b0, 1'b1);
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", o_sb_msg_valid, 1'b0);
    check("mid_rst_final", o_final_lanes, 2'b11);
    check("mid_rst_flags", {o_repairmb_done, o_repairmb_error}, 2'b00);
    check("mid_rst_pulses", {o_test_start, o_start_setup}, 2'b00);
    @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
    check("post_rst_idle_valid", o_sb_msg_valid, 1'b0);
    run_txn(2'b11, 2'b10, 2, 3, 1'b0, 1'b0);

    // Randomized passes
    for (int n = 0; n < 14; n++) begin
      run_txn(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(0, 4),
              $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
